qspi_mem_model: RTL

QSPI_MEM_MODEL -- requirements
Module: qspi_mem_model

---
 rtl/qspi_mem_model.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/qspi_mem_model.sv
// Behavioural quad-SPI memory model with CHANNELS independent byte arrays and chip selects.
// Read command 0x0B is always present; write command 0x02 exists only when QSPI_MEM_WRITE_EN is defined.
module qspi_mem_model #(
  parameter int CHANNELS     = 3,
  parameter int DEPTH        = 4096,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                qspi_clk,
  input  logic [CHANNELS-1:0] qspi_cs_n,
  input  logic [3:0]          qspi_data_in,
  output logic [3:0]          qspi_data_out,
  output logic [3:0]          qspi_data_oe,
  output logic                busy,
  output logic                cmd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] CMD_READ = 8'h0B;
`ifdef QSPI_MEM_WRITE_EN
  localparam logic [7:0] CMD_WRITE = 8'h02;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    READ   = 3'd4,
    WRITE  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic                sck_q;
  logic                sck_rise, sck_fall;
  logic [CHANNELS-1:0] cs_low;
  logic                cs_none, cs_one;
  logic [CW-1:0]       cs_idx;
  logic [CW-1:0]       ch_q;
  logic [2:0]          nib_cnt_q;
  logic [7:0]          cmd_q;
  logic [7:0]          cmd_byte;
  logic                cmd_legal;
  logic [AW-1:0]       addr_q;
  logic [3:0]          dummy_q;
  logic                half_q;
  logic [3:0]          data_out_q;
  logic [3:0]          oe_q;
  logic                cmd_err_q;
  logic [7:0]          rd_byte;

  logic [7:0] mem [CHANNELS][DEPTH];

  assign sck_rise = qspi_clk & ~sck_q;
  assign sck_fall = ~qspi_clk & sck_q;
  assign cs_low   = ~qspi_cs_n;
  assign cs_none  = &qspi_cs_n;
  assign cs_one   = ($countones(cs_low) == 1);
  assign cmd_byte = {cmd_q[3:0], qspi_data_in};
  assign rd_byte  = mem[ch_q][addr_q];

`ifdef QSPI_MEM_WRITE_EN
  assign cmd_legal = (cmd_byte == CMD_READ) || (cmd_byte == CMD_WRITE);
`else
  assign cmd_legal = (cmd_byte == CMD_READ);
`endif

  always_comb begin
    cs_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cs_low[i]) cs_idx = CW'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; deselecting every channel wins over everything else
  always_comb begin
    state_d = state_q;
    if (cs_none) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = cs_one ? CMD : IGNORE;
        CMD:     if (sck_rise && nib_cnt_q == 3'd1) state_d = cmd_legal ? ADDR : IGNORE;
        ADDR:    if (sck_rise && nib_cnt_q == 3'd5) state_d = (cmd_q == CMD_READ) ? DUMMY : WRITE;
        DUMMY:   if (sck_rise && dummy_q == 4'(DUMMY_CYCLES - 1)) state_d = READ;
        default: state_d = state_q;
      endcase
    end
  end

  // Shift registers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= 1'b0;
      ch_q       <= '0;
      nib_cnt_q  <= 3'd0;
      cmd_q      <= 8'h00;
      addr_q     <= '0;
      dummy_q    <= 4'd0;
      half_q     <= 1'b0;
      data_out_q <= 4'h0;
      oe_q       <= 4'h0;
      cmd_err_q  <= 1'b0;
    end else begin
      sck_q     <= qspi_clk;
      cmd_err_q <= 1'b0;
      if (cs_none) begin
        nib_cnt_q  <= 3'd0;
        dummy_q    <= 4'd0;
        half_q     <= 1'b0;
        data_out_q <= 4'h0;
        oe_q       <= 4'h0;
      end else begin
        case (state_q)
          IDLE: begin
            nib_cnt_q <= 3'd0;
            dummy_q   <= 4'd0;
            half_q    <= 1'b0;
            if (cs_one) ch_q <= cs_idx;
            else        cmd_err_q <= 1'b1;
          end
          CMD: if (sck_rise) begin
            cmd_q <= cmd_byte;
            if (nib_cnt_q == 3'd1) begin
              nib_cnt_q <= 3'd0;
              if (!cmd_legal) cmd_err_q <= 1'b1;
            end else begin
              nib_cnt_q <= nib_cnt_q + 3'd1;
            end
          end
          ADDR: if (sck_rise) begin
            // Only the low AW bits survive the shift, giving address modulo DEPTH
            addr_q <= AW'({addr_q, qspi_data_in});
            if (nib_cnt_q == 3'd5) nib_cnt_q <= 3'd0;
            else                   nib_cnt_q <= nib_cnt_q + 3'd1;
          end
          DUMMY: if (sck_rise) dummy_q <= dummy_q + 4'd1;
          READ: if (sck_fall) begin
            oe_q       <= 4'hF;
            data_out_q <= half_q ? rd_byte[3:0] : rd_byte[7:4];
            half_q     <= ~half_q;
            if (half_q) addr_q <= addr_q + AW'(1);
          end
`ifdef QSPI_MEM_WRITE_EN
          WRITE: if (sck_rise) begin
            half_q <= ~half_q;
            if (half_q) addr_q <= addr_q + AW'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef QSPI_MEM_WRITE_EN
  logic [3:0] wr_hi_q;
  logic       wr_fire;

  assign wr_fire = !cs_none && (state_q == WRITE) && sck_rise && half_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              wr_hi_q <= 4'h0;
    else if (!cs_none && state_q == WRITE && sck_rise && !half_q) wr_hi_q <= qspi_data_in;
  end

  // Memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) mem[ch_q][addr_q] <= {wr_hi_q, qspi_data_in};
  end
`else
  // Without a write command the array can only be filled from simulation
  task automatic preload(input logic [CW-1:0] ch, input logic [AW-1:0] addr,
                         input logic [7:0] data);
    mem[ch][addr] = data;
  endtask
`endif

  // Output logic
  always_comb begin
    busy          = (state_q != IDLE);
    cmd_err       = cmd_err_q;
    qspi_data_out = data_out_q;
    qspi_data_oe  = (state_q == READ) ? oe_q : 4'h0;
  end

endmodule
